// File: rtl/patch_unpatchifier_if.sv
// rtl/patch_unpatchifier_if.sv - patch-major input stream and raster output stream of the unpatchifier
interface patch_unpatchifier_if #(
    parameter int PIXEL_WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PIXEL_WIDTH-1:0] in_pixel;
    logic                   out_valid;
    logic                   out_ready;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic                   out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/patch_unpatchifier.sv
// rtl/patch_unpatchifier.sv - buffers one patch-major frame, then streams it out in raster order
module patch_unpatchifier #(
    parameter int CHANNEL_SIZE    = 8,
    parameter int NUM_CHANNELS    = 3,
    parameter int PIXEL_WIDTH     = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH       = 16,
    parameter int IMG_HEIGHT      = 16,
    parameter int PATCH_SIZE      = 4,
    parameter int PATCH_SIZE_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       output_taken,
    output logic       done,
    output logic [2:0] state,
    patch_unpatchifier_if.slave s
);
    localparam int PATCHES_X = IMG_WIDTH / PATCH_SIZE;
    localparam int PATCHES_Y = IMG_HEIGHT / PATCH_SIZE;
    localparam int PX_W      = (PATCHES_X > 1) ? $clog2(PATCHES_X) : 1;
    localparam int PY_W      = (PATCHES_Y > 1) ? $clog2(PATCHES_Y) : 1;
    localparam int PS_W      = PATCH_SIZE_LOG2;
    localparam int COL_W     = $clog2(IMG_WIDTH);
    localparam int ROW_W     = $clog2(IMG_HEIGHT);
    localparam int ADDR_W    = $clog2(IMG_WIDTH * IMG_HEIGHT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [PS_W-1:0]   pos_col_q, pos_col_d, pos_row_q, pos_row_d;
    logic [PX_W-1:0]   patch_col_q, patch_col_d;
    logic [PY_W-1:0]   patch_row_q, patch_row_d;
    logic [ROW_W-1:0]  r_q, r_d;
    logic [COL_W-1:0]  c_q, c_d;

    logic [PIXEL_WIDTH-1:0] frame_q [IMG_WIDTH*IMG_HEIGHT];

    logic              accept, beat, pos_col_end, pos_row_end, patch_col_end, patch_row_end;
    logic              last_out;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign accept        = (state_q == FILL) && s.in_valid && in_ready_q;
    assign beat          = (state_q == DRAIN) && s.out_ready;
    assign pos_col_end   = (pos_col_q == PS_W'(PATCH_SIZE - 1));
    assign pos_row_end   = (pos_row_q == PS_W'(PATCH_SIZE - 1));
    assign patch_col_end = (patch_col_q == PX_W'(PATCHES_X - 1));
    assign patch_row_end = (patch_row_q == PY_W'(PATCHES_Y - 1));
    assign last_out      = (r_q == ROW_W'(IMG_HEIGHT - 1)) && (c_q == COL_W'(IMG_WIDTH - 1));

    // Patch origin is the patch index scaled by the patch edge, offset by the in-patch position.
    assign wr_row  = (ROW_W'(patch_row_q) << PATCH_SIZE_LOG2) + ROW_W'(pos_row_q);
    assign wr_col  = (COL_W'(patch_col_q) << PATCH_SIZE_LOG2) + COL_W'(pos_col_q);
    assign wr_addr = ADDR_W'(wr_row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(wr_col);
    assign rd_addr = ADDR_W'(r_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(c_q);

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = (state_q == DRAIN);
    assign s.out_last  = (state_q == DRAIN) && last_out;
    assign s.out_pixel = (state_q == DRAIN) ? frame_q[rd_addr] : '0;
    assign done        = (state_q == DONE);
    assign state       = state_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        pos_col_d   = pos_col_q;
        pos_row_d   = pos_row_q;
        patch_col_d = patch_col_q;
        patch_row_d = patch_row_q;
        r_d         = r_q;
        c_d         = c_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = FILL;
                    in_ready_d  = 1'b1;
                    pos_col_d   = '0;
                    pos_row_d   = '0;
                    patch_col_d = '0;
                    patch_row_d = '0;
                    r_d         = '0;
                    c_d         = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    pos_col_d = pos_col_end ? '0 : pos_col_q + 1'b1;
                    if (pos_col_end) begin
                        pos_row_d = pos_row_end ? '0 : pos_row_q + 1'b1;
                        if (pos_row_end) begin
                            patch_col_d = patch_col_end ? '0 : patch_col_q + 1'b1;
                            if (patch_col_end) begin
                                patch_row_d = patch_row_end ? '0 : patch_row_q + 1'b1;
                                if (patch_row_end) begin
                                    state_d    = DRAIN;
                                    in_ready_d = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (beat) begin
                    if (c_q == COL_W'(IMG_WIDTH - 1)) begin
                        c_d = '0;
                        r_d = last_out ? '0 : r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                    if (last_out) state_d = DONE;
                end
            end
            DONE: begin
                if (output_taken) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            pos_col_q   <= '0;
            pos_row_q   <= '0;
            patch_col_q <= '0;
            patch_row_q <= '0;
            r_q         <= '0;
            c_q         <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pos_col_q   <= pos_col_d;
            pos_row_q   <= pos_row_d;
            patch_col_q <= patch_col_d;
            patch_row_q <= patch_row_d;
            r_q         <= r_d;
            c_q         <= c_d;
        end
    end

    // Frame storage carries no reset; every location is rewritten before a drain reads it.
    always_ff @(posedge clk) begin
        if (accept) frame_q[wr_addr] <= s.in_pixel;
    end
endmodule

// File: tb/tb_patch_unpatchifier.sv
// tb/tb_patch_unpatchifier.sv - directed bench for patch_unpatchifier (4x4 and 8x8 patch instances)
module tb_patch_unpatchifier;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          output_taken = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_pixel = '0;
    logic          out_ready = 1'b0;
    logic          done, done8;
    logic [2:0]    state, state8;

    patch_unpatchifier_if #(.PIXEL_WIDTH(PW)) ifc ();
    patch_unpatchifier_if #(.PIXEL_WIDTH(PW)) ifc8 ();

    assign ifc.in_valid   = in_valid;
    assign ifc.in_pixel   = in_pixel;
    assign ifc.out_ready  = out_ready;
    assign ifc8.in_valid  = in_valid;
    assign ifc8.in_pixel  = in_pixel;
    assign ifc8.out_ready = out_ready;

    patch_unpatchifier u_dut (
        .clk(clk), .reset(reset), .en(en), .output_taken(output_taken),
        .done(done), .state(state), .s(ifc.slave)
    );

    patch_unpatchifier #(.PATCH_SIZE(8), .PATCH_SIZE_LOG2(3)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .output_taken(output_taken),
        .done(done8), .state(state8), .s(ifc8.slave)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [PW-1:0] got  [256];
    logic [PW-1:0] got8 [256];
    int            fill_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp4(input int idx);
        int r = idx / 16;
        int c = idx % 16;
        return ((r >> 2) * 4 + (c >> 2)) * 16 + (r & 3) * 4 + (c & 3);
    endfunction

    function automatic int exp8(input int idx);
        int r = idx / 16;
        int c = idx % 16;
        return ((r >> 3) * 2 + (c >> 3)) * 64 + (r & 7) * 8 + (c & 7);
    endfunction

    task automatic start_frame();
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic feed(input int base, input int limit, input bit toggle, input bit en_hold);
        int k = 0;
        int i = 0;
        bit v, acc;
        while (k < limit && i < 3000) begin
            @(negedge clk);
            en       = en_hold;
            v        = toggle ? (i % 2 == 1) : 1'b1;
            in_valid = v;
            in_pixel = PW'(base + k);
            acc      = v && ifc.in_ready;
            i++;
            @(posedge clk);
            if (acc) k++;
        end
        #1 in_valid = 1'b0;
        fill_cycles = i;
        check("fill_count", k, limit);
        if (limit == 256) begin
            check("fill_to_drain", state, 3'd2);
            check("in_ready_drop", ifc.in_ready, 1'b0);
        end
    endtask

    task automatic drain(input bit stall, input bit noise);
        int            beat = 0;
        int            b8 = 0;
        int            i = 0;
        int            last_idx = -1;
        int            last_cnt = 0;
        bit            held = 1'b0;
        logic [PW-1:0] hold_px = '0;
        logic          hold_last = 1'b0;
        while (beat < 256 && i < 3000) begin
            @(negedge clk);
            out_ready    = stall ? (i % 4 == 3) : 1'b1;
            en           = noise;
            output_taken = noise;
            if (held) begin
                check("stall_px", ifc.out_pixel, hold_px);
                check("stall_last", ifc.out_last, hold_last);
            end
            held      = ifc.out_valid && !out_ready;
            hold_px   = ifc.out_pixel;
            hold_last = ifc.out_last;
            if (ifc.out_valid && out_ready) begin
                got[beat] = ifc.out_pixel;
                if (ifc.out_last) begin
                    last_idx = beat;
                    last_cnt++;
                end
                beat++;
            end
            if (ifc8.out_valid && out_ready && b8 < 256) begin
                got8[b8] = ifc8.out_pixel;
                b8++;
            end
            i++;
        end
        check("drain_beats", beat, 256);
        check("last_idx", last_idx, 255);
        check("last_cnt", last_cnt, 1);
        @(negedge clk);
        out_ready    = 1'b0;
        en           = 1'b0;
        output_taken = 1'b0;
        check("done_state", state, 3'd3);
        check("done_flag", done, 1'b1);
        check("done_out_valid", ifc.out_valid, 1'b0);
    endtask

    task automatic finish_frame(input int hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_hold", done, 1'b1);
            check("done_hold_state", state, 3'd3);
        end
        @(negedge clk);
        output_taken = 1'b1;
        @(negedge clk);
        output_taken = 1'b0;
        check("idle_state", state, 3'd0);
        check("idle_done", done, 1'b0);
        check("idle_out_valid", ifc.out_valid, 1'b0);
        check("idle_out_pixel", ifc.out_pixel, 0);
    endtask

    task automatic verify(input int base, input bit with8);
        for (int idx = 0; idx < 256; idx++)
            check($sformatf("px%0d", idx), got[idx], base + exp4(idx));
        if (with8)
            for (int idx = 0; idx < 256; idx++)
                check($sformatf("p8_px%0d", idx), got8[idx], exp8(idx));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_in_ready", ifc.in_ready, 1'b0);
        check("rst_out_valid", ifc.out_valid, 1'b0);
        check("rst_out_last", ifc.out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_pixel", ifc.out_pixel, 0);
        reset = 1'b0;

        // Continuous fill and drain, both patch sizes
        start_frame();
        feed(0, 256, 1'b0, 1'b0);
        check("fill_cycles_cont", fill_cycles, 256);
        drain(1'b0, 1'b0);
        finish_frame(0);
        verify(0, 1'b1);
        check("raster4", got[4], 16);
        check("raster16", got[16], 4);
        check("raster255", got[255], 255);
        check("p8_raster8", got8[8], 64);
        check("p8_raster16", got8[16], 8);

        // in_valid toggling every other cycle
        start_frame();
        feed(0, 256, 1'b1, 1'b0);
        check("fill_cycles_toggle", fill_cycles, 512);
        drain(1'b0, 1'b0);
        finish_frame(0);
        verify(0, 1'b0);

        // Output backpressure three cycles out of four
        start_frame();
        feed(0, 256, 1'b0, 1'b0);
        drain(1'b1, 1'b0);
        finish_frame(0);
        verify(0, 1'b0);

        // Reset mid-fill, then a clean frame
        start_frame();
        feed(0, 100, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_state", state, 3'd0);
        check("midrst_in_ready", ifc.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        start_frame();
        feed(1000, 256, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        finish_frame(0);
        verify(1000, 1'b0);

        // en and output_taken outside their states are ignored
        start_frame();
        feed(0, 256, 1'b0, 1'b1);
        drain(1'b0, 1'b1);
        finish_frame(5);
        verify(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
